// File: rtl/sysid_checker.sv
// Reads the sysid slave's ID (word 0) and timestamp (word 1), captures both and
// compares them with the build-time expected values; flags drive status/LED logic.
module sysid_checker #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter logic [31:0] EXPECTED_ID    = 32'd792046559,
  parameter logic [31:0] EXPECTED_TS    = 32'd1296687325,
  parameter bit          CHECK_TS       = 1'b1,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned RECHECK_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] sysid_readdata,
  output logic        sysid_address,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  mismatch_count
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

  localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY);
  localparam logic [23:0] RECHK_LAST = 24'((RECHECK_PERIOD == 0) ? 0 : RECHECK_PERIOD - 1);
  localparam bit          RECHK_EN   = (RECHECK_PERIOD != 0);

  state_t      state, state_nx;
  logic [1:0]  lat_cnt, lat_cnt_nx;
  logic [23:0] rechk_cnt, rechk_cnt_nx;
  logic        auto_pend;
  logic        launch;
  logic        lat_last;
  logic        rechk_exp;
  logic        match;

  assign lat_last  = (lat_cnt == LAT_LAST);
  assign rechk_exp = RECHK_EN && (rechk_cnt == RECHK_LAST);
  assign match     = (id_value == EXPECTED_ID) && (!CHECK_TS || (ts_value == EXPECTED_TS));

  always_comb begin
    state_nx     = state;
    lat_cnt_nx   = lat_cnt;
    rechk_cnt_nx = rechk_cnt;
    launch       = 1'b0;
    case (state)
      IDLE: begin
        // start, auto-start and recheck expiry all funnel into one launch
        launch = start || auto_pend || rechk_exp;
        if (launch) begin
          state_nx     = RD_ID;
          lat_cnt_nx   = '0;
          rechk_cnt_nx = '0;
        end else if (RECHK_EN) begin
          rechk_cnt_nx = rechk_cnt + 24'd1;
        end
      end
      RD_ID: begin
        if (lat_last) begin
          state_nx   = RD_TS;
          lat_cnt_nx = '0;
        end else begin
          lat_cnt_nx = lat_cnt + 2'd1;
        end
      end
      RD_TS: begin
        if (lat_last) begin
          state_nx   = CMP;
          lat_cnt_nx = '0;
        end else begin
          lat_cnt_nx = lat_cnt + 2'd1;
        end
      end
      CMP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      rechk_cnt      <= '0;
      auto_pend      <= AUTO_START;
      sysid_address  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      id_ok          <= 1'b0;
      id_value       <= '0;
      ts_value       <= '0;
      mismatch_count <= '0;
    end else begin
      state         <= state_nx;
      lat_cnt       <= lat_cnt_nx;
      rechk_cnt     <= rechk_cnt_nx;
      // auto-start is honoured only on the first edge after reset release
      auto_pend     <= 1'b0;
      sysid_address <= (state_nx == RD_TS);
      busy          <= (state_nx != IDLE);
      if (launch) begin
        done <= 1'b0;
      end
      if ((state == RD_ID) && lat_last) begin
        id_value <= sysid_readdata;
      end
      if ((state == RD_TS) && lat_last) begin
        ts_value <= sysid_readdata;
      end
      if (state == CMP) begin
        id_ok <= match;
        done  <= 1'b1;
        if (!match && (mismatch_count != 8'hFF)) begin
          mismatch_count <= mismatch_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: four instances cover the default build,
// CHECK_TS=0, READ_LATENCY=2 and RECHECK_PERIOD=10 configurations.
module tb_sysid_checker;

  localparam logic [31:0] ID_GOOD = 32'd792046559;
  localparam logic [31:0] TS_GOOD = 32'd1296687325;
  localparam logic [31:0] BAD_ID  = 32'h12345678;
  localparam logic [31:0] BAD_TS  = 32'hDEADBEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // instance a: defaults (L=0, CHECK_TS=1, AUTO_START=1, no recheck)
  logic rst_a = 1'b0, st_a = 1'b0;
  logic [31:0] mid_a = ID_GOOD, mts_a = TS_GOOD, rd_a;
  logic addr_a, busy_a, done_a, ok_a;
  logic [31:0] idv_a, tsv_a;
  logic [7:0] mc_a;
  assign rd_a = addr_a ? mts_a : mid_a;

  // instance b: CHECK_TS=0, AUTO_START=0
  logic rst_b = 1'b0, st_b = 1'b0;
  logic [31:0] mid_b = ID_GOOD, mts_b = TS_GOOD, rd_b;
  logic addr_b, busy_b, done_b, ok_b;
  logic [31:0] idv_b, tsv_b;
  logic [7:0] mc_b;
  assign rd_b = addr_b ? mts_b : mid_b;

  // instance c: READ_LATENCY=2, AUTO_START=0, slave delays data two cycles
  logic rst_c = 1'b0, st_c = 1'b0;
  logic [31:0] mid_c = ID_GOOD, mts_c = TS_GOOD, p1_c, p2_c;
  logic addr_c, busy_c, done_c, ok_c;
  logic [31:0] idv_c, tsv_c;
  logic [7:0] mc_c;
  always_ff @(posedge clock) begin
    p1_c <= addr_c ? mts_c : mid_c;
    p2_c <= p1_c;
  end

  // instance d: RECHECK_PERIOD=10, AUTO_START=0
  logic rst_d = 1'b0, st_d = 1'b0;
  logic [31:0] mid_d = ID_GOOD, mts_d = TS_GOOD, rd_d;
  logic addr_d, busy_d, done_d, ok_d;
  logic [31:0] idv_d, tsv_d;
  logic [7:0] mc_d;
  assign rd_d = addr_d ? mts_d : mid_d;

  sysid_checker u_a (
    .clock(clock), .reset_n(rst_a), .start(st_a), .sysid_readdata(rd_a),
    .sysid_address(addr_a), .busy(busy_a), .done(done_a), .id_ok(ok_a),
    .id_value(idv_a), .ts_value(tsv_a), .mismatch_count(mc_a));

  sysid_checker #(.CHECK_TS(1'b0), .AUTO_START(1'b0)) u_b (
    .clock(clock), .reset_n(rst_b), .start(st_b), .sysid_readdata(rd_b),
    .sysid_address(addr_b), .busy(busy_b), .done(done_b), .id_ok(ok_b),
    .id_value(idv_b), .ts_value(tsv_b), .mismatch_count(mc_b));

  sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) u_c (
    .clock(clock), .reset_n(rst_c), .start(st_c), .sysid_readdata(p2_c),
    .sysid_address(addr_c), .busy(busy_c), .done(done_c), .id_ok(ok_c),
    .id_value(idv_c), .ts_value(tsv_c), .mismatch_count(mc_c));

  sysid_checker #(.AUTO_START(1'b0), .RECHECK_PERIOD(10)) u_d (
    .clock(clock), .reset_n(rst_d), .start(st_d), .sysid_readdata(rd_d),
    .sysid_address(addr_d), .busy(busy_d), .done(done_d), .id_ok(ok_d),
    .id_value(idv_d), .ts_value(tsv_d), .mismatch_count(mc_d));

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_a, done_a, ok_a, addr_a} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy_a, done_a, ok_a, addr_a});
    else n_pass++;
    n_total++;
    if ({idv_a, tsv_a} !== 64'd0)
      $display("FAIL reset_values: got id=%h ts=%h want 0/0", idv_a, tsv_a);
    else n_pass++;
    n_total++;
    if (mc_a !== 8'd0) $display("FAIL reset_count: got %0d want 0", mc_a);
    else n_pass++;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (4) @(negedge clock);
    n_total++;
    if ({busy_b, done_b, busy_c, done_c} !== 4'b0000)
      $display("FAIL no_autostart_idle: got %b want 0000", {busy_b, done_b, busy_c, done_c});
    else n_pass++;
  endtask

  task automatic test_auto_start();
    logic [2:0] aseq = 3'b010;
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if ({busy_a, done_a, addr_a} !== {1'b1, 1'b0, aseq[i]})
        $display("FAIL auto_busy_c%0d: got %b want %b", i, {busy_a, done_a, addr_a}, {1'b1, 1'b0, aseq[i]});
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if ({busy_a, done_a, ok_a} !== 3'b011)
      $display("FAIL auto_done: got %b want 011", {busy_a, done_a, ok_a});
    else n_pass++;
    n_total++;
    if (idv_a !== ID_GOOD || tsv_a !== TS_GOOD)
      $display("FAIL auto_capture: got id=%h ts=%h want id=%h ts=%h", idv_a, tsv_a, ID_GOOD, TS_GOOD);
    else n_pass++;
    n_total++;
    if (mc_a !== 8'd0) $display("FAIL auto_count: got %0d want 0", mc_a);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    mid_a = BAD_ID;
    st_a = 1'b1;
    @(negedge clock);
    st_a = 1'b0;
    n_total++;
    if ({busy_a, done_a} !== 2'b10)
      $display("FAIL launch_clears_done: got %b want 10", {busy_a, done_a});
    else n_pass++;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_a, done_a, ok_a} !== 3'b010)
      $display("FAIL bad_id_flags: got %b want 010", {busy_a, done_a, ok_a});
    else n_pass++;
    n_total++;
    if (mc_a !== 8'd1 || idv_a !== BAD_ID)
      $display("FAIL bad_id_count: got cnt=%0d id=%h want cnt=1 id=%h", mc_a, idv_a, BAD_ID);
    else n_pass++;
    for (int i = 0; i < 300; i++) begin
      st_a = 1'b1;
      @(negedge clock);
      st_a = 1'b0;
      repeat (3) @(negedge clock);
      if (i == 252) begin
        n_total++;
        if (mc_a !== 8'd254) $display("FAIL count_254: got %0d want 254", mc_a);
        else n_pass++;
      end
    end
    n_total++;
    if (mc_a !== 8'd255 || ok_a !== 1'b0)
      $display("FAIL count_saturate: got cnt=%0d ok=%b want cnt=255 ok=0", mc_a, ok_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mid_a = ID_GOOD;
    st_a = 1'b1;
    @(negedge clock);
    st_a = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_a, done_a, ok_a} !== 3'b011 || mc_a !== 8'd255)
      $display("FAIL good_after_sat: got flags=%b cnt=%0d want 011/255", {busy_a, done_a, ok_a}, mc_a);
    else n_pass++;
    mts_a = BAD_TS;
    st_a = 1'b1;
    @(negedge clock);
    st_a = 1'b0;
    n_total++;
    if ({busy_a, done_a, ok_a} !== 3'b101 || idv_a !== ID_GOOD)
      $display("FAIL b2b_launch_hold: got flags=%b id=%h want 101 id=%h", {busy_a, done_a, ok_a}, idv_a, ID_GOOD);
    else n_pass++;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_a, done_a, ok_a} !== 3'b010 || tsv_a !== BAD_TS)
      $display("FAIL ts_bad_checked: got flags=%b ts=%h want 010 ts=%h", {busy_a, done_a, ok_a}, tsv_a, BAD_TS);
    else n_pass++;
    mts_a = TS_GOOD;
  endtask

  task automatic test_check_ts_off();
    mts_b = BAD_TS;
    st_b = 1'b1;
    @(negedge clock);
    st_b = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_b, done_b, ok_b} !== 3'b011)
      $display("FAIL ts_off_flags: got %b want 011", {busy_b, done_b, ok_b});
    else n_pass++;
    n_total++;
    if (tsv_b !== BAD_TS || idv_b !== ID_GOOD || mc_b !== 8'd0)
      $display("FAIL ts_off_capture: got ts=%h id=%h cnt=%0d want ts=%h id=%h cnt=0", tsv_b, idv_b, mc_b, BAD_TS, ID_GOOD);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [6:0] aseq = 7'b0111000;
    st_c = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      st_c = 1'b0;
      n_total++;
      if ({busy_c, done_c, addr_c} !== {1'b1, 1'b0, aseq[i]})
        $display("FAIL lat_cycle%0d: got %b want %b", i, {busy_c, done_c, addr_c}, {1'b1, 1'b0, aseq[i]});
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if ({busy_c, done_c, ok_c} !== 3'b011)
      $display("FAIL lat_done: got %b want 011", {busy_c, done_c, ok_c});
    else n_pass++;
    n_total++;
    if (idv_c !== ID_GOOD || tsv_c !== TS_GOOD)
      $display("FAIL lat_capture: got id=%h ts=%h want id=%h ts=%h", idv_c, tsv_c, ID_GOOD, TS_GOOD);
    else n_pass++;
  endtask

  task automatic test_reset_mid_check();
    mts_c = BAD_TS;
    st_c = 1'b1;
    @(negedge clock);
    st_c = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({busy_c, addr_c} !== 2'b11)
      $display("FAIL in_rd_ts: got %b want 11", {busy_c, addr_c});
    else n_pass++;
    rst_c = 1'b0;
    @(negedge clock);
    n_total++;
    if ({busy_c, done_c, ok_c, addr_c} !== 4'b0000 || mc_c !== 8'd0)
      $display("FAIL abort_flags: got %b cnt=%0d want 0000 cnt=0", {busy_c, done_c, ok_c, addr_c}, mc_c);
    else n_pass++;
    n_total++;
    if ({idv_c, tsv_c} !== 64'd0)
      $display("FAIL abort_values: got id=%h ts=%h want 0/0", idv_c, tsv_c);
    else n_pass++;
    rst_c = 1'b1;
    repeat (6) @(negedge clock);
    n_total++;
    if ({busy_c, done_c} !== 2'b00)
      $display("FAIL stay_idle: got %b want 00", {busy_c, done_c});
    else n_pass++;
    mts_c = TS_GOOD;
    st_c = 1'b1;
    @(negedge clock);
    st_c = 1'b0;
    repeat (7) @(negedge clock);
    n_total++;
    if ({busy_c, done_c, ok_c} !== 3'b011 || mc_c !== 8'd0)
      $display("FAIL after_abort: got %b cnt=%0d want 011 cnt=0", {busy_c, done_c, ok_c}, mc_c);
    else n_pass++;
  endtask

  // Launches expected at edges 10 (recheck), 23 (start + recheck together)
  // and 36 (recheck); the start pulsed during the second check is dropped.
  task automatic test_recheck();
    logic eb, ed;
    rst_d = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      @(negedge clock);
      eb = (c >= 10 && c <= 12) || (c >= 23 && c <= 25) || (c >= 36 && c <= 38);
      ed = (c >= 13) && !eb;
      n_total++;
      if ({busy_d, done_d} !== {eb, ed})
        $display("FAIL recheck_c%0d: got busy/done=%b want %b", c, {busy_d, done_d}, {eb, ed});
      else n_pass++;
      st_d = (c == 22) || (c == 24);
    end
    n_total++;
    if (ok_d !== 1'b1 || mc_d !== 8'd0)
      $display("FAIL recheck_result: got ok=%b cnt=%0d want 1/0", ok_d, mc_d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_mismatch();
    test_back_to_back();
    test_check_ts_off();
    test_latency();
    test_reset_mid_check();
    test_recheck();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
